// File: rtl/rc4_ksa_core.sv
// RC4 key-scheduling engine: identity-fills an external single-port S memory,
// then runs the KSA shuffle with a latched key of KEY_LEN elements.
module rc4_ksa_core #(
  parameter int AW      = 8,
  parameter int KEY_LEN = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  init_only,
  input  logic [AW*KEY_LEN-1:0] secret_key,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         mem_address,
  output logic [AW-1:0]         mem_data,
  output logic                  mem_wren,
  input  logic [AW-1:0]         mem_q
);

  localparam int            KW   = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [KW-1:0] KMAX = KW'(KEY_LEN - 1);
  localparam logic [AW-1:0] IMAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RD_I, S_RD_J, S_WR_J, S_WR_I, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         i_q, i_d;
  logic [AW-1:0]         j_q, j_d;
  logic [AW-1:0]         si_q, si_d;
  logic [AW-1:0]         sj_q, sj_d;
  logic [KW-1:0]         kidx_q, kidx_d;
  logic [AW*KEY_LEN-1:0] key_q, key_d;
  logic                  init_only_q, init_only_d;
  logic [AW-1:0]         key_el;
  logic [AW-1:0]         jn;

  // Element 0 of the key is the most-significant slice.
  always_comb begin
    key_el = '0;
    for (int k = 0; k < KEY_LEN; k++) begin
      if (kidx_q == KW'(k)) key_el = key_q[AW*(KEY_LEN-k)-1 -: AW];
    end
  end

  assign jn = j_q + mem_q + key_el;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers are always reloaded on start, so they carry no reset.
  always_ff @(posedge clk) begin
    i_q         <= i_d;
    j_q         <= j_d;
    si_q        <= si_d;
    sj_q        <= sj_d;
    kidx_q      <= kidx_d;
    key_q       <= key_d;
    init_only_q <= init_only_d;
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    kidx_d      = kidx_q;
    key_d       = key_q;
    init_only_d = init_only_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d       = secret_key;
          init_only_d = init_only;
          i_d         = '0;
          j_d         = '0;
          kidx_d      = '0;
          state_d     = S_INIT;
        end
      end
      S_INIT: begin
        if (i_q == IMAX) begin
          i_d     = '0;
          state_d = init_only_q ? S_DONE : S_RD_I;
        end else begin
          i_d = i_q + AW'(1);
        end
      end
      S_RD_I: state_d = S_RD_J;
      S_RD_J: begin
        si_d    = mem_q;
        j_d     = jn;
        state_d = S_WR_J;
      end
      S_WR_J: begin
        sj_d    = mem_q;
        state_d = S_WR_I;
      end
      S_WR_I: begin
        if (i_q == IMAX) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + AW'(1);
          kidx_d  = (kidx_q == KMAX) ? '0 : kidx_q + KW'(1);
          state_d = S_RD_I;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // S[i] and S[j] are both read before either swap write, so i==j needs no bypass.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    unique case (state_q)
      S_INIT: begin
        busy        = 1'b1;
        mem_address = i_q;
        mem_data    = i_q;
        mem_wren    = 1'b1;
      end
      S_RD_I: begin
        busy        = 1'b1;
        mem_address = i_q;
      end
      S_RD_J: begin
        busy        = 1'b1;
        mem_address = jn;
      end
      S_WR_J: begin
        busy        = 1'b1;
        mem_address = j_q;
        mem_data    = si_q;
        mem_wren    = 1'b1;
      end
      S_WR_I: begin
        busy        = 1'b1;
        mem_address = i_q;
        mem_data    = sj_q;
        mem_wren    = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_ksa_core.sv
// Bench for rc4_ksa_core: three instances (AW/KEY_LEN = 8/3, 2/1, 4/16), each
// with its own synchronous single-port memory, checked against an RC4 KSA model.
module tb_rc4_ksa_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance 0: AW=8, KEY_LEN=3
  logic st8 = 1'b0, io8 = 1'b0, busy8, done8, wren8;
  logic [23:0] key8 = '0;
  logic [7:0]  addr8, data8, q8;
  logic [7:0]  mem8 [256];
  // Instance 1: AW=2, KEY_LEN=1
  logic st2 = 1'b0, io2 = 1'b0, busy2, done2, wren2;
  logic [1:0]  key2 = '0;
  logic [1:0]  addr2, data2, q2;
  logic [1:0]  mem2 [4];
  // Instance 2: AW=4, KEY_LEN=16
  logic st4 = 1'b0, io4 = 1'b0, busy4, done4, wren4;
  logic [63:0] key4 = '0;
  logic [3:0]  addr4, data4, q4;
  logic [3:0]  mem4 [16];

  rc4_ksa_core #(.AW(8), .KEY_LEN(3)) u8 (
    .clk(clk), .reset(reset), .start(st8), .init_only(io8), .secret_key(key8),
    .busy(busy8), .done(done8), .mem_address(addr8), .mem_data(data8),
    .mem_wren(wren8), .mem_q(q8));
  rc4_ksa_core #(.AW(2), .KEY_LEN(1)) u2 (
    .clk(clk), .reset(reset), .start(st2), .init_only(io2), .secret_key(key2),
    .busy(busy2), .done(done2), .mem_address(addr2), .mem_data(data2),
    .mem_wren(wren2), .mem_q(q2));
  rc4_ksa_core #(.AW(4), .KEY_LEN(16)) u4 (
    .clk(clk), .reset(reset), .start(st4), .init_only(io4), .secret_key(key4),
    .busy(busy4), .done(done4), .mem_address(addr4), .mem_data(data4),
    .mem_wren(wren4), .mem_q(q4));

  // Synchronous memories, read data one cycle after the address.
  always @(posedge clk) begin
    if (wren8) mem8[addr8] <= data8;
    q8 <= mem8[addr8];
    if (wren2) mem2[addr2] <= data2;
    q2 <= mem2[addr2];
    if (wren4) mem4[addr4] <= data4;
    q4 <= mem4[addr4];
  end

  int   sel_cur = 0;
  logic cur_done, cur_busy, cur_wren;
  always_comb begin
    cur_done = done8; cur_busy = busy8; cur_wren = wren8;
    case (sel_cur)
      1: begin cur_done = done2; cur_busy = busy2; cur_wren = wren2; end
      2: begin cur_done = done4; cur_busy = busy4; cur_wren = wren4; end
      default: ;
    endcase
  end

  function automatic int aw_of(input int sel);
    return (sel == 0) ? 8 : (sel == 1) ? 2 : 4;
  endfunction
  function automatic int kl_of(input int sel);
    return (sel == 0) ? 3 : (sel == 1) ? 1 : 16;
  endfunction

  function automatic int get_mem(input int sel, input int idx);
    logic [7:0] a;
    a = idx[7:0];
    case (sel)
      1:       return int'(mem2[a[1:0]]);
      2:       return int'(mem4[a[3:0]]);
      default: return int'(mem8[a]);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference KSA: standard RC4 loop with modulo arithmetic.
  int exp_s [256];
  task automatic model(input int aw, input int klen, input logic [127:0] key, input bit io);
    int n;
    int j;
    int t;
    int kv [$];
    logic [127:0] sh;
    n = 1 << aw;
    for (int x = 0; x < n; x++) exp_s[x] = x;
    if (!io) begin
      for (int kk = 0; kk < klen; kk++) begin
        sh = key >> (aw * (klen - 1 - kk));
        kv.push_back(int'(sh[7:0]) % n);
      end
      j = 0;
      for (int x = 0; x < n; x++) begin
        j = (j + exp_s[x] + kv[x % klen]) % n;
        t = exp_s[x]; exp_s[x] = exp_s[j]; exp_s[j] = t;
      end
    end
  endtask

  task automatic cmp_mem(input int sel, input string nm);
    int n;
    int bad;
    n = 1 << aw_of(sel);
    bad = -1;
    for (int x = 0; x < n; x++) begin
      if (bad < 0 && get_mem(sel, x) != exp_s[x]) bad = x;
    end
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL %s: S[%0d] got %0d expected %0d", nm, bad, get_mem(sel, bad), exp_s[bad]);
    end
  endtask

  task automatic set_in(input int sel, input bit st, input bit io, input logic [127:0] key);
    case (sel)
      1:       begin st2 = st; io2 = io; key2 = key[1:0];  end
      2:       begin st4 = st; io4 = io; key4 = key[63:0]; end
      default: begin st8 = st; io8 = io; key8 = key[23:0]; end
    endcase
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive start for one edge; afterwards keep scrambling the key and mode.
  task automatic kick(input int sel, input bit io, input logic [127:0] key, input bit pulse);
    sel_cur = sel;
    @(negedge clk);
    set_in(sel, 1'b1, io, key);
    @(posedge clk);
    #1;
    set_in(sel, pulse, ~io, rnd128());
  endtask

  task automatic watch(input int sel, input bit pulse, output int lat, output int wr,
                       output int bb, output int post);
    lat = -1; wr = 0; bb = 0;
    for (int m = 1; m <= 4000; m++) begin
      @(negedge clk);
      if (cur_wren) wr++;
      if (cur_done) begin lat = m; break; end
      if (!cur_busy) bb++;
      if (pulse) set_in(sel, 1'b1, 1'($urandom_range(0, 1)), rnd128());
    end
    @(negedge clk);
    post = int'(cur_done) + int'(cur_busy);
    set_in(sel, 1'b0, 1'b0, rnd128());
  endtask

  task automatic do_run(input int sel, input bit io, input logic [127:0] key, input bit pulse,
                        input int exp_lat, input int exp_wr, input string tag);
    int lat, wr, bb, post;
    model(aw_of(sel), kl_of(sel), key, io);
    kick(sel, io, key, pulse);
    watch(sel, pulse, lat, wr, bb, post);
    chk({tag, "_done_latency"}, lat, exp_lat);
    chk({tag, "_write_cycles"}, wr, exp_wr);
    chk({tag, "_busy_gaps"}, bb, 0);
    chk({tag, "_after_done"}, post, 0);
    cmp_mem(sel, {tag, "_memory"});
  endtask

  typedef struct {
    int          sel;
    bit          io;
    logic [127:0] key;
    int          lat;
    int          wr;
    bit          has_fixed;
    logic [7:0]  fixed;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int n, lat, wr, bb, post, hits;
    logic [127:0] k;
    logic [7:0] fx;

    tbl[0] = '{1, 1'b0, 128'h0,                  21,   12,  1'b1, 8'h78};
    tbl[1] = '{1, 1'b1, 128'h0,                  5,    4,   1'b1, 8'hE4};
    tbl[2] = '{0, 1'b0, 128'h000249,             1281, 768, 1'b0, 8'h00};
    tbl[3] = '{2, 1'b0, 128'h0123456789abcdef,   81,   48,  1'b0, 8'h00};
    tbl[4] = '{0, 1'b1, 128'h0,                  257,  256, 1'b0, 8'h00};
    tbl[5] = '{2, 1'b1, 128'h0,                  17,   16,  1'b0, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_aw8", int'({busy8, done8, wren8, addr8, data8}), 0);
    chk("reset_outputs_aw2", int'({busy2, done2, wren2, addr2, data2}), 0);
    chk("reset_outputs_aw4", int'({busy4, done4, wren4, addr4, data4}), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs_aw8", int'({busy8, done8, wren8, addr8, data8}), 0);

    for (int v = 0; v < 6; v++) begin
      do_run(tbl[v].sel, tbl[v].io, tbl[v].key, 1'b0, tbl[v].lat, tbl[v].wr,
             $sformatf("vec%0d", v));
      if (tbl[v].has_fixed) begin
        fx = tbl[v].fixed;
        for (int x = 0; x < 4; x++)
          chk($sformatf("vec%0d_fixed_S%0d", v, x), get_mem(1, x), int'(fx[2*x +: 2]));
      end
    end

    // Reset in the middle of the shuffle at i=100, then a clean run.
    kick(0, 1'b0, rnd128(), 1'b0);
    repeat (657) @(negedge clk);
    chk("abort_point_address", int'(addr8), 100);
    chk("abort_point_busy", int'(busy8), 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_outputs", int'({busy8, done8, wren8, addr8, data8}), 0);
    @(negedge clk);
    reset = 1'b0;
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      hits += int'(done8) + int'(busy8);
    end
    chk("abort_no_done", hits, 0);
    do_run(0, 1'b0, 128'h000001, 1'b0, 1281, 768, "after_abort");

    // start held high every cycle and key/mode scrambled while busy.
    do_run(0, 1'b0, 128'hA5C3_17, 1'b1, 1281, 768, "start_spam8");
    do_run(2, 1'b0, rnd128(), 1'b1, 81, 48, "start_spam4");

    // Randomised keys and modes on every instance.
    for (int r = 0; r < 9; r++) begin
      int s;
      bit io;
      s  = r % 3;
      io = ($urandom_range(0, 3) == 0);
      n  = 1 << aw_of(s);
      k  = rnd128();
      do_run(s, io, k, 1'b0, io ? n + 1 : 5 * n + 1, io ? n : 3 * n,
             $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rc4_ksa_core.md
# rc4_ksa_core

Parametrised RC4 key-scheduling engine: fills the S-box memory with the identity permutation, then runs the RC4 key-scheduling shuffle with a configurable-length secret key. It is a single FSM that drives one synchronous single-port S memory directly. It sits between the board top level and the s_memory instance, and later hands the memory to the decrypt stage. Generalises the fixed 256-entry / 3-byte-key flow to any power-of-two S size and any key length, and adds an init-only mode and a start/busy/done handshake.

## Interface
- AW, default 8: address width and S-entry width; S size N = 2^AW.
- KEY_LEN, default 3: number of key elements, each AW bits wide; range 1..N.
- clk  in  1: single clock.
- reset  in  1: asynchronous, active-high reset.
- start  in  1: request a run; sampled only in IDLE.
- init_only  in  1: sampled with start; 1 = identity fill only, skip the shuffle.
- secret_key  in  AW*KEY_LEN: key; element k = secret_key[AW*(KEY_LEN-k)-1 -: AW], so element 0 is the most-significant slice. Latched at start.
- busy  out  1: high from the cycle after start is accepted until done.
- done  out  1: one-cycle pulse when the run completes.
- mem_address  out  AW: S memory address.
- mem_data  out  AW: S memory write data.
- mem_wren  out  1: S memory write enable.
- mem_q  in  AW: S memory read data. Returns data for the address presented in the previous cycle (1-cycle read latency).

## Operation
- Internal state: i (AW bits), j (AW bits), kidx (key index, 0..KEY_LEN-1, wraps without division), si (AW bits, holds S[i]), latched key, latched mode.
- IDLE: busy=0, mem_wren=0.
  - On start=1: latch secret_key and init_only, clear i/j/kidx, go to INIT.
- INIT, one cycle per i: mem_address=i, mem_data=i, mem_wren=1.
  - At i=N-1: go to DONE if init_only, else clear i and go to RD_I.
- RD_I: mem_address=i, mem_wren=0.
- RD_J:
  - Compute jn = (j + mem_q + key[kidx]) mod N.
  - Latch si=mem_q and j=jn.
  - Present mem_address=jn, mem_wren=0.
- WR_J: mem_address=j, mem_data=si, mem_wren=1. Capture mem_q (= S[j]) into a holding register.
- WR_I: mem_address=i, mem_data=held S[j], mem_wren=1.
  - At i=N-1: go to DONE.
  - Otherwise: i++, advance kidx (KEY_LEN-1 wraps to 0), go to RD_I.
- i==j case: both writes store the same value, so S is unchanged. No bypass is needed, because the read of S[j] occurs before either write.
- DONE: done=1 for one cycle, mem_wren=0, then return to IDLE. start in this cycle is ignored.
- start while busy: ignored. secret_key changes after acceptance have no effect.
- All arithmetic is unsigned modulo 2^AW.

## Timing
- Reset values: busy=0, done=0, mem_wren=0, mem_address=0, mem_data=0. Internal state returns to IDLE.
- Reset mid-run: abort immediately. Memory contents are undefined; no done pulse is generated.
- Start accepted at edge k:
  - INIT writes occupy cycles k+1..k+N.
  - Shuffle takes 4 cycles per i: cycles k+N+1..k+5N.
  - done is high in cycle k+5N+1; busy is high k+1..k+5N.
- init_only run: done is high in cycle k+N+1.
- New start is accepted at the earliest in the cycle after done, i.e. the first IDLE cycle.
- Exactly one mem_wren-high cycle per INIT step and two per shuffle step. Total writes per run: N + 2N.

## Test plan
- AW=2, KEY_LEN=1, key=0, full run -> final memory [0,2,3,1]; done exactly 21 cycles after the start edge (5N+1, N=4).
- AW=2, init_only=1 -> memory [0,1,2,3]; done 5 cycles after start; no writes after cycle k+4.
- AW=8, KEY_LEN=3, key=24'h000249, full run -> memory equals the software RC4 KSA model byte-for-byte; exactly 768 write cycles; done at k+1281.
- Assert reset during the shuffle at i=100 -> all outputs 0 on the same edge. Then start with key=24'h000001 -> run completes, result matches the model.
- Pulse start every cycle while busy, and toggle secret_key after acceptance -> single done pulse; result matches the originally latched key.
- AW=4, KEY_LEN=16 (kidx never wraps early) and KEY_LEN=1 -> results match the model; busy never drops mid-run.
